// File: rtl/instruction_fetch.sv
// Instruction fetch front end: sequential PC generation, one outstanding memory read,
// and a 2-entry {pc, instr} buffer presented to the datapath with valid/ready.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_en,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               mem_rd,
    output logic [DEPTH_W-1:0] mem_addr,
    input  logic [31:0]        mem_data,
    output logic [31:0]        instr_out,
    output logic [31:0]        pc_out,
    output logic               instr_valid,
    input  logic               instr_ready
);

    // Handshake: the head entry transfers on any cycle where instr_valid and instr_ready
    // are both high; while instr_ready is low the presented pc/instr are held unchanged.

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        pending_q, pending_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] pc0_q, pc0_d, pc1_q, pc1_d;
    logic [31:0] ins0_q, ins0_d, ins1_q, ins1_d;

    logic        pop;
    logic        push;
    logic [2:0]  occupancy;
    logic [1:0]  count_after_pop;

    always_comb begin
        instr_valid = rst_n && (count_q != 2'd0) && !redirect;
        pop         = instr_valid && instr_ready;
        // Entries held plus the read in flight, minus what leaves this cycle.
        occupancy   = {1'b0, count_q} + {2'b00, pending_q} - {2'b00, pop};
        mem_rd      = rst_n && fetch_en && !redirect && (occupancy < 3'd2);
        mem_addr    = fetch_pc_q[DEPTH_W+1:2];
        instr_out   = (rst_n && count_q != 2'd0) ? ins0_q : 32'h0;
        pc_out      = (rst_n && count_q != 2'd0) ? pc0_q  : 32'h0;
        push        = pending_q && !redirect;

        fetch_pc_d      = fetch_pc_q;
        pend_pc_d       = pend_pc_q;
        pending_d       = 1'b0;
        count_d         = count_q;
        pc0_d           = pc0_q;
        pc1_d           = pc1_q;
        ins0_d          = ins0_q;
        ins1_d          = ins1_q;
        count_after_pop = count_q - {1'b0, pop};

        if (redirect) begin
            count_d    = 2'd0;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else begin
            if (pop) begin
                pc0_d  = pc1_q;
                ins0_d = ins1_q;
            end
            if (push) begin
                if (count_after_pop == 2'd0) begin
                    pc0_d  = pend_pc_q;
                    ins0_d = mem_data;
                end else begin
                    pc1_d  = pend_pc_q;
                    ins1_d = mem_data;
                end
            end
            count_d = count_after_pop + {1'b0, push};
            if (mem_rd) begin
                pend_pc_d  = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + 32'd4;
                pending_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= 32'h0;
            pending_q  <= 1'b0;
            count_q    <= 2'd0;
            pc0_q      <= 32'h0;
            pc1_q      <= 32'h0;
            ins0_q     <= 32'h0;
            ins1_q     <= 32'h0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            pending_q  <= pending_d;
            count_q    <= count_d;
            pc0_q      <= pc0_d;
            pc1_q      <= pc1_d;
            ins0_q     <= ins0_d;
            ins1_q     <= ins1_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: bench-side instruction memory, a queue-based fetch model
// checked every cycle, and literal expectations for the directed scenarios.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic [31:0] mem_data;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        instr_ready;

    int vectors     = 0;
    int miscompares = 0;

    instruction_fetch #(.RESET_PC(32'h0000_0000), .DEPTH_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .redirect(redirect),
        .redirect_pc(redirect_pc), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_data(mem_data), .instr_out(instr_out), .pc_out(pc_out),
        .instr_valid(instr_valid), .instr_ready(instr_ready)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- instruction memory ----------------
    logic [31:0] mem [256];
    logic        rd_s;
    logic [7:0]  addr_s;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
        mem_data = 32'hBAD0_BAD0;
        rd_s = 1'b0;
        addr_s = 8'h0;
    end

    always @(negedge clk) begin
        rd_s   = mem_rd;
        addr_s = mem_addr;
    end

    always @(posedge clk) begin
        #1 mem_data = rd_s ? mem[addr_s] : 32'hBAD0_BAD0;
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: fetch address, queue of buffered pcs, and one in-flight read.
    logic [31:0] m_fpc = 32'h0;
    logic [31:0] m_q[$];
    bit          m_pend = 1'b0;
    logic [31:0] m_pend_pc = 32'h0;
    bit          started = 1'b0;
    int          cyc = 0;

    logic [31:0] del_pc[$], del_ins[$];
    int          del_cyc[$], rd_cyc[$];
    logic [7:0]  rd_addr[$];

    always @(negedge clk) begin
        if (started) begin
            if (!rst_n) begin
                chk("rst_mem_rd", {31'b0, mem_rd}, 32'd0);
                chk("rst_valid", {31'b0, instr_valid}, 32'd0);
                chk("rst_instr", instr_out, 32'h0);
                chk("rst_pc", pc_out, 32'h0);
                m_q.delete();
                m_pend = 1'b0;
                m_fpc = 32'h0;
                cyc = 0;
            end else begin
                automatic bit e_valid = (m_q.size() != 0) && !redirect;
                automatic bit e_pop   = e_valid && instr_ready;
                automatic bit e_rd    = fetch_en && !redirect &&
                                        ((m_q.size() + int'(m_pend) - int'(e_pop)) < 2);
                chk("mem_rd", {31'b0, mem_rd}, {31'b0, e_rd});
                if (e_rd) chk("mem_addr", {24'b0, mem_addr}, {24'b0, m_fpc[9:2]});
                chk("instr_valid", {31'b0, instr_valid}, {31'b0, e_valid});
                if (m_q.size() != 0) begin
                    chk("pc_out", pc_out, m_q[0]);
                    chk("instr_out", instr_out, mem[m_q[0][9:2]]);
                end else begin
                    chk("pc_out_empty", pc_out, 32'h0);
                    chk("instr_out_empty", instr_out, 32'h0);
                end
                if (instr_valid && instr_ready) begin
                    del_pc.push_back(pc_out);
                    del_ins.push_back(instr_out);
                    del_cyc.push_back(cyc);
                end
                if (mem_rd) begin
                    rd_addr.push_back(mem_addr);
                    rd_cyc.push_back(cyc);
                end
                if (redirect) begin
                    m_q.delete();
                    m_pend = 1'b0;
                    m_fpc = {redirect_pc[31:2], 2'b00};
                end else begin
                    if (e_pop) void'(m_q.pop_front());
                    if (m_pend) m_q.push_back(m_pend_pc);
                    m_pend = e_rd;
                    if (e_rd) begin
                        m_pend_pc = m_fpc;
                        m_fpc = m_fpc + 32'd4;
                    end
                end
                cyc++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        del_pc.delete(); del_ins.delete(); del_cyc.delete();
        rd_addr.delete(); rd_cyc.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(1);
        clear_logs();
        rst_n = 1'b1;
    endtask

    task automatic pulse_redirect(input logic [31:0] target);
        redirect = 1'b1;
        redirect_pc = target;
        tick(1);
        redirect = 1'b0;
    endtask

    task automatic need(input string name, input int have, input int n);
        chk(name, {31'b0, have >= n}, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; fetch_en = 1'b0; redirect = 1'b0;
        redirect_pc = 32'h0; instr_ready = 1'b1;
        tick(1);
        started = 1'b1;
        tick(1);

        // Streaming after reset: first read cycle 0, first output cycle 2.
        clear_logs();
        rst_n = 1'b1; fetch_en = 1'b1;
        tick(8);
        need("s1_del_len", del_pc.size(), 4);
        chk("s1_rd_cyc0", rd_cyc[0], 0);
        chk("s1_rd_addr0", {24'b0, rd_addr[0]}, 32'd0);
        chk("s1_del_cyc0", del_cyc[0], 2);
        for (int k = 0; k < 4; k++) begin
            chk("s1_del_pc", del_pc[k], 32'(4 * k));
            chk("s1_del_ins", del_ins[k], 32'hA000_0000 + k);
        end
        chk("s1_del_cyc3", del_cyc[3], 5);

        // Back-pressure from cycle 2 for five cycles, then drain without gaps.
        do_reset();
        tick(2);
        instr_ready = 1'b0;
        tick(5);
        instr_ready = 1'b1;
        tick(4);
        need("s2_del_len", del_pc.size(), 3);
        chk("s2_del_cyc0", del_cyc[0], 7);
        chk("s2_del_ins0", del_ins[0], 32'hA000_0000);
        chk("s2_del_cyc1", del_cyc[1], 8);
        chk("s2_del_ins1", del_ins[1], 32'hA000_0001);
        chk("s2_del_cyc2", del_cyc[2], 9);
        chk("s2_del_ins2", del_ins[2], 32'hA000_0002);
        need("s2_rd_len", rd_cyc.size(), 3);
        chk("s2_rd_cyc2", rd_cyc[2], 7);

        // Redirect to an unaligned target while the buffer is full.
        instr_ready = 1'b0;
        tick(3);
        clear_logs();
        instr_ready = 1'b1;
        pulse_redirect(32'h0000_0043);
        tick(4);
        need("s3_del_len", del_pc.size(), 1);
        chk("s3_rd_addr0", {24'b0, rd_addr[0]}, 32'd16);
        chk("s3_del_pc0", del_pc[0], 32'h0000_0040);
        chk("s3_del_ins0", del_ins[0], 32'hA000_0010);
        chk("s3_latency", del_cyc[0] - rd_cyc[0], 2);

        // Word index wraps while pc_out keeps the full address.
        clear_logs();
        pulse_redirect(32'h0000_03FC);
        tick(4);
        need("s4_del_len", del_pc.size(), 2);
        chk("s4_rd_addr0", {24'b0, rd_addr[0]}, 32'd255);
        chk("s4_rd_addr1", {24'b0, rd_addr[1]}, 32'd0);
        chk("s4_del_pc0", del_pc[0], 32'h0000_03FC);
        chk("s4_del_ins0", del_ins[0], 32'hA000_00FF);
        chk("s4_del_pc1", del_pc[1], 32'h0000_0400);
        chk("s4_del_ins1", del_ins[1], 32'hA000_0000);

        // Back-to-back redirects: only the second target is delivered.
        clear_logs();
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        tick(1);
        redirect_pc = 32'h0000_0204;
        tick(1);
        redirect = 1'b0;
        tick(4);
        need("s5_del_len", del_pc.size(), 2);
        chk("s5_del_pc0", del_pc[0], 32'h0000_0204);
        chk("s5_del_ins0", del_ins[0], 32'hA000_0081);
        chk("s5_del_pc1", del_pc[1], 32'h0000_0208);

        // fetch_en dropped with a read in flight, then re-enabled.
        do_reset();
        tick(1);
        fetch_en = 1'b0;
        tick(3);
        fetch_en = 1'b1;
        tick(5);
        need("s6_del_len", del_pc.size(), 3);
        chk("s6_rd_cyc1", rd_cyc[1], 4);
        chk("s6_rd_addr1", {24'b0, rd_addr[1]}, 32'd1);
        chk("s6_del_cyc0", del_cyc[0], 2);
        chk("s6_del_pc0", del_pc[0], 32'h0);
        chk("s6_del_cyc1", del_cyc[1], 6);
        chk("s6_del_pc1", del_pc[1], 32'h4);
        chk("s6_del_pc2", del_pc[2], 32'h8);

        // One-cycle reset mid-stream: in-flight data never shows up.
        pulse_redirect(32'h0000_0300);
        tick(3);
        do_reset();
        tick(5);
        need("s7_del_len", del_pc.size(), 2);
        chk("s7_del_cyc0", del_cyc[0], 2);
        chk("s7_del_pc0", del_pc[0], 32'h0);
        chk("s7_del_ins0", del_ins[0], 32'hA000_0000);
        chk("s7_del_pc1", del_pc[1], 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address of first fetch after reset.
REQ-002 Parameter DEPTH_W, default 8, word-index width of instruction memory (256 words).
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 fetch_en  input  1  permit new memory reads.
REQ-006 redirect  input  1  branch/jump taken, flush and restart.
REQ-007 redirect_pc  input  32  new byte address, bits [1:0] ignored.
REQ-008 mem_rd  output  1  instruction memory read strobe.
REQ-009 mem_addr  output  DEPTH_W  word index = fetch_pc[DEPTH_W+1:2].
REQ-010 mem_data  input  32  read data, valid the cycle after mem_rd.
REQ-011 instr_out  output  32  head instruction to datapath.
REQ-012 pc_out  output  32  byte address of instr_out.
REQ-013 instr_valid  output  1  instr_out/pc_out valid.
REQ-014 instr_ready  input  1  datapath accepts head; transfer = instr_valid & instr_ready.

Function
REQ-015 State: fetch_pc (32b), 2-entry buffer of {pc,instr}, count 0..2, pending flag for one outstanding read, pend_pc.
REQ-016 pop = instr_valid & instr_ready; mem_rd = fetch_en & !redirect & (count + pending - pop) < 2, combinational from instr_ready.
REQ-017 On mem_rd: mem_addr from fetch_pc, pend_pc <= fetch_pc, fetch_pc <= fetch_pc + 4 (mod 2^32, wraps to 0), pending <= 1.
REQ-018 Pending read without new issue clears pending next edge; data captured at end of the cycle mem_data is valid.
REQ-019 Buffer in FIFO order; simultaneous push and pop keeps count; push never occurs when it would exceed 2 (guaranteed by REQ-016).
REQ-020 instr_valid = (count != 0) & !redirect; instr_out/pc_out = head entry; zero when count = 0.
REQ-021 Latency: read issued in cycle t -> instruction valid at output in cycle t+2; sustained throughput 1 instr/cycle when instr_ready held high.
REQ-022 instr_ready low with count = 2: no reads, outputs held stable until accepted.
REQ-023 fetch_en low: no new reads; outstanding read still captured; buffered entries still delivered.
REQ-024 redirect high: count <= 0, outstanding read data discarded (pending cleared, arriving mem_data ignored), fetch_pc <= {redirect_pc[31:2],2'b00}, no mem_rd, no transfer that cycle.
REQ-025 First read from redirect target issued cycle after redirect (if fetch_en); its instruction valid two cycles after that.
REQ-026 Redirect repeated on consecutive cycles: last one wins, nothing delivered between.
REQ-027 Redirect in same cycle as arriving mem_data: data dropped.
REQ-028 mem_addr wraps modulo 2^DEPTH_W; pc_out reports full 32-bit fetch address.

Reset
REQ-029 rst_n low at rising edge: fetch_pc <= RESET_PC, count <= 0, pending <= 0, buffer contents <= 0.
REQ-030 During and after reset until first capture: mem_rd follows REQ-016 only once rst_n high; instr_valid = 0, instr_out = 0, pc_out = 0.
REQ-031 Reset asserted mid-stream overrides redirect and in-flight reads; data returning after reset is discarded.

Verification
REQ-032 Reset, fetch_en=1, ready=1, mem[i]=32'hA000_0000+i -> mem_rd cycle 0 addr 0; valid cycle 2 instr A000_0000 pc 0; then one instr/cycle, pc 4, 8, 12.
REQ-033 ready=0 from cycle 2 for 5 cycles -> count reaches 2, mem_rd low, instr_out stays A000_0000; ready=1 -> A000_0001, A000_0002 consecutive, no gap.
REQ-034 Redirect to 32'h0000_0043 while count=2 and read pending -> valid low next cycle, mem_addr=16 (pc 0x40) next cycle, first output pc_out=0x40 two cycles later, no stale word delivered.
REQ-035 DEPTH_W=8, redirect_pc=32'h0000_03FC, streaming -> mem_addr 255 then 0; pc_out 0x3FC then 0x400.
REQ-036 fetch_en dropped with a read pending -> that word still delivered, no further mem_rd; re-enable resumes at next sequential pc.
REQ-037 rst_n low for one cycle during streaming -> next cycle valid=0, restart at RESET_PC, returning in-flight data never appears.
